// File: rtl/usb_sniffer_axi_slv_req.sv
// AXI4 slave to single-channel request bridge: AW/W/AR bursts become one registered
// request per W beat or per AR; B/R responses pass straight through.
module usb_sniffer_axi_slv_req (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inport_awvalid_i,
  input  logic [31:0] inport_awaddr_i,
  input  logic [3:0]  inport_awid_i,
  input  logic [7:0]  inport_awlen_i,
  input  logic [1:0]  inport_awburst_i,
  output logic        inport_awready_o,
  input  logic        inport_wvalid_i,
  input  logic [31:0] inport_wdata_i,
  input  logic [3:0]  inport_wstrb_i,
  input  logic        inport_wlast_i,
  output logic        inport_wready_o,
  input  logic        inport_arvalid_i,
  input  logic [31:0] inport_araddr_i,
  input  logic [3:0]  inport_arid_i,
  input  logic [7:0]  inport_arlen_i,
  input  logic [1:0]  inport_arburst_i,
  output logic        inport_arready_o,
  input  logic        inport_bready_i,
  input  logic        inport_rready_i,
  output logic        inport_bvalid_o,
  output logic [1:0]  inport_bresp_o,
  output logic [3:0]  inport_bid_o,
  output logic        inport_rvalid_o,
  output logic [31:0] inport_rdata_o,
  output logic [1:0]  inport_rresp_o,
  output logic [3:0]  inport_rid_o,
  output logic        inport_rlast_o,
  output logic        outport_valid_o,
  output logic        outport_write_o,
  output logic [31:0] outport_addr_o,
  output logic [3:0]  outport_id_o,
  output logic [7:0]  outport_len_o,
  output logic [1:0]  outport_burst_o,
  output logic [31:0] outport_wdata_o,
  output logic [3:0]  outport_wstrb_o,
  input  logic        outport_accept_i,
  input  logic        outport_bvalid_i,
  input  logic [1:0]  outport_bresp_i,
  input  logic [3:0]  outport_bid_i,
  input  logic        outport_rvalid_i,
  input  logic [31:0] outport_rdata_i,
  input  logic [1:0]  outport_rresp_i,
  input  logic [3:0]  outport_rid_i,
  input  logic        outport_rlast_i,
  output logic        outport_bready_o,
  output logic        outport_rready_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // ready never waits on anything the master does after valid, and valid holds until taken.
  typedef enum logic {ST_IDLE = 1'b0, ST_WRITE = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        prio_q, prio_d;  // 1: read wins the next AW/AR tie
  logic [7:0]  beat_cnt_q, beat_cnt_d;
  logic [31:0] aw_addr_q, aw_addr_d;
  logic [3:0]  aw_id_q, aw_id_d;
  logic [7:0]  aw_len_q, aw_len_d;
  logic [1:0]  aw_burst_q, aw_burst_d;

  logic        valid_q, valid_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  id_q, id_d;
  logic [7:0]  len_q, len_d;
  logic [1:0]  burst_q, burst_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;

  logic free_w;
  logic grant_wr;
  logic grant_rd;
  logic w_fire;
  logic ar_fire;

  always_comb begin
    free_w   = !valid_q || outport_accept_i;
    grant_wr = (state_q == ST_IDLE) && inport_awvalid_i && (!inport_arvalid_i || !prio_q);
    grant_rd = (state_q == ST_IDLE) && inport_arvalid_i && (!inport_awvalid_i || prio_q);

    inport_awready_o = grant_wr;
    inport_arready_o = grant_rd && free_w;
    inport_wready_o  = (state_q == ST_WRITE) && free_w;

    w_fire  = inport_wvalid_i && inport_wready_o;
    ar_fire = inport_arvalid_i && inport_arready_o;

    state_d    = state_q;
    prio_d     = prio_q;
    beat_cnt_d = beat_cnt_q;
    aw_addr_d  = aw_addr_q;
    aw_id_d    = aw_id_q;
    aw_len_d   = aw_len_q;
    aw_burst_d = aw_burst_q;
    valid_d    = valid_q;
    write_d    = write_q;
    addr_d     = addr_q;
    id_d       = id_q;
    len_d      = len_q;
    burst_d    = burst_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;

    if (grant_wr) begin
      state_d    = ST_WRITE;
      prio_d     = 1'b1;
      beat_cnt_d = 8'd0;
      aw_addr_d  = inport_awaddr_i;
      aw_id_d    = inport_awid_i;
      aw_len_d   = inport_awlen_i;
      aw_burst_d = inport_awburst_i;
    end

    if (ar_fire) begin
      prio_d  = 1'b0;
      write_d = 1'b0;
      addr_d  = inport_araddr_i;
      id_d    = inport_arid_i;
      len_d   = inport_arlen_i;
      burst_d = inport_arburst_i;
      wdata_d = 32'd0;
      wstrb_d = 4'd0;
    end else if (w_fire) begin
      write_d = 1'b1;
      addr_d  = aw_addr_q;
      id_d    = aw_id_q;
      len_d   = aw_len_q;
      burst_d = aw_burst_q;
      wdata_d = inport_wdata_i;
      wstrb_d = inport_wstrb_i;
      // Burst length comes from the captured len alone; wlast is not trusted.
      if (beat_cnt_q == aw_len_q) begin
        state_d    = ST_IDLE;
        beat_cnt_d = 8'd0;
      end else begin
        beat_cnt_d = beat_cnt_q + 8'd1;
      end
    end

    if (ar_fire || w_fire) begin
      valid_d = 1'b1;
    end else if (outport_accept_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      prio_q     <= 1'b0;
      beat_cnt_q <= 8'd0;
      aw_addr_q  <= 32'd0;
      aw_id_q    <= 4'd0;
      aw_len_q   <= 8'd0;
      aw_burst_q <= 2'd0;
      valid_q    <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= 32'd0;
      id_q       <= 4'd0;
      len_q      <= 8'd0;
      burst_q    <= 2'd0;
      wdata_q    <= 32'd0;
      wstrb_q    <= 4'd0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      beat_cnt_q <= beat_cnt_d;
      aw_addr_q  <= aw_addr_d;
      aw_id_q    <= aw_id_d;
      aw_len_q   <= aw_len_d;
      aw_burst_q <= aw_burst_d;
      valid_q    <= valid_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      id_q       <= id_d;
      len_q      <= len_d;
      burst_q    <= burst_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
    end
  end

  assign outport_valid_o = valid_q;
  assign outport_write_o = write_q;
  assign outport_addr_o  = addr_q;
  assign outport_id_o    = id_q;
  assign outport_len_o   = len_q;
  assign outport_burst_o = burst_q;
  assign outport_wdata_o = wdata_q;
  assign outport_wstrb_o = wstrb_q;

  assign inport_bvalid_o  = outport_bvalid_i;
  assign inport_bresp_o   = outport_bresp_i;
  assign inport_bid_o     = outport_bid_i;
  assign inport_rvalid_o  = outport_rvalid_i;
  assign inport_rdata_o   = outport_rdata_i;
  assign inport_rresp_o   = outport_rresp_i;
  assign inport_rid_o     = outport_rid_i;
  assign inport_rlast_o   = outport_rlast_i;
  assign outport_bready_o = inport_bready_i;
  assign outport_rready_o = inport_rready_i;

  logic unused_wlast;
  assign unused_wlast = inport_wlast_i;

endmodule

// File: doc/usb_sniffer_axi_slv_req.md
# usb_sniffer_axi_slv_req

AXI4 slave-to-request bridge for the USB sniffer. Accepts AXI4 AW/W/AR bursts on its slave port and serialises them onto the single-channel request stream (valid/write/addr/id/len/burst/wdata/wstrb with accept) used by the sniffer's internal memory path. This is the inverse of the request-to-AXI master bridge. Write and read responses pass straight through from the request-side slave back to the AXI master.

## Interface
Parameters: none (fixed widths: addr 32, data 32, id 4, len 8).

Ports (grouped buses share direction; widths listed in order):
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- inport_awvalid_i / awaddr_i / awid_i / awlen_i / awburst_i  in  1/32/4/8/2  AXI write address
- inport_awready_o  out  1  write address accept
- inport_wvalid_i / wdata_i / wstrb_i / wlast_i  in  1/32/4/1  AXI write data
- inport_wready_o  out  1  write data accept
- inport_arvalid_i / araddr_i / arid_i / arlen_i / arburst_i  in  1/32/4/8/2  AXI read address
- inport_arready_o  out  1  read address accept
- inport_bready_i, inport_rready_i  in  1  AXI response ready, forwarded
- inport_bvalid_o / bresp_o / bid_o  out  1/2/4  = outport_bvalid_i / bresp_i / bid_i
- inport_rvalid_o / rdata_o / rresp_o / rid_o / rlast_o  out  1/32/2/4/1  = outport_r*_i
- outport_valid_o / write_o / addr_o / id_o / len_o / burst_o / wdata_o / wstrb_o  out  1/1/32/4/8/2/32/4  request stream, registered
- outport_accept_i  in  1  request consumed this cycle
- outport_bvalid_i / bresp_i / bid_i, outport_rvalid_i / rdata_i / rresp_i / rid_i / rlast_i  in  response from slave
- outport_bready_o, outport_rready_o  out  1  = inport_bready_i, inport_rready_i

## Operation
- State machine: IDLE, WRITE.
- Output holding register (valid_q + payload). `free_w = !valid_q || outport_accept_i`.
- Arbiter in IDLE:
  - AW only -> grant write; AR only -> grant read.
  - Both valid -> grant per prio_q (reset = write).
  - Every grant sets prio_q to the opposite type.
- IDLE, write grant: `awready_o = 1` (independent of free_w); capture awaddr/awid/awlen/awburst; clear beat_cnt; go to WRITE.
- IDLE, read grant: `arready_o = free_w`.
  - On handshake, load register with write=0, araddr/arid/arlen/arburst, wdata=0, wstrb=0.
  - Stay in IDLE. One request per AR regardless of arlen; the slave returns arlen+1 R beats.
- WRITE: `wready_o = free_w`; `awready_o = arready_o = 0`.
  - Each W handshake loads the register with write=1, captured addr/id/len/burst (identical for every beat), wdata_i, wstrb_i. Then beat_cnt += 1.
  - When beat_cnt == captured len on a handshake, return to IDLE.
  - Burst end is defined by the counter; wlast_i is ignored.
  - len=255 yields 256 beats; the counter never wraps.
- Register update: if a load occurs, valid_q=1; else if outport_accept_i, valid_q=0. Load and accept in the same cycle keeps valid_q=1 with the new payload.
- W beats presented in IDLE are not accepted (`wready_o = 0`).
- Response channels are pure combinational wires with no buffering.

## Timing
- Reset values: all outport_* request outputs 0; awready_o / wready_o / arready_o 0 (state IDLE, prio_q write, beat_cnt 0, valid_q 0). Passthrough outputs follow their inputs.
- awready_o, arready_o, wready_o are combinational from state, prio_q, valid_q, outport_accept_i, and the valid inputs.
- AW handshake at cycle N -> WRITE at N+1; first W beat can be accepted at N+1.
- W or AR handshake at cycle M -> outport_valid_o = 1 at M+1.
- With outport_accept_i held high, throughput is 1 beat per cycle. A len=L write occupies L+2 cycles from AW to the last request.
- Read after write: AR can be accepted the cycle after the last W beat, provided free_w.
- Reset asserted mid-burst: state returns to IDLE immediately; the pending request and the remaining burst are dropped. The master must also be reset.

## Test plan
- Single write: AW addr=0x1000, id=3, len=0; W data=0xDEADBEEF, strb=0xF -> one request write=1, addr=0x1000, id=3, len=0, wdata=0xDEADBEEF; back to IDLE.
- Burst len=3, accept toggled 1/0 -> 4 requests in order, all with addr=0x2000 and len=3. wready_o is low while valid_q=1 and accept=0. No beat is lost or duplicated.
- Read: AR addr=0x3000, id=5, len=7 -> one request write=0, len=7. Eight R beats driven on outport_r* appear unchanged on inport_r*, including rlast.
- Contention: AW and AR valid together three times from reset -> grant order write, read, write.
- Back-to-back: accept tied high, len=255 -> 256 consecutive-cycle requests. wlast_i asserted early at beat 10 -> ignored, still 256 beats.
- Reset at beat 2 of a len=3 burst -> outport_valid_o=0 next edge, state IDLE. A following AR is accepted normally.
